instr_mem_pipe: RTL and testbench

Parametrised, synchronous-read instruction memory for the fetch stage, superseding the flat combinational instruction store. It zero-clears its array after reset, then serves one registered fetch per cycle with stall and flush control. A separate load port writes program images and reads words back. It sits between the PC/fetch logic and the decode pipeline register; the load port is driven by the boot loader or the testbench.

---
 rtl/instr_mem_pipe_if.sv | 33 +++
 rtl/instr_mem_pipe.sv | 71 +++++++
 tb/tb_instr_mem_pipe.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/instr_mem_pipe_if.sv
// instr_mem_pipe_if: fetch and load-port bundle for instr_mem_pipe
// Ports (slave = memory side):
//    init_done                     memory ready
//    fetch_req/addr/stall/flush    fetch request and pipeline control
//    fetch_ready/valid/data/err    fetch acceptance and registered result
//    load_we/re/addr/wdata/rdata   program load / readback port
interface instr_mem_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  init_done;
   logic                  fetch_req;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  fetch_ready;
   logic                  fetch_stall;
   logic                  fetch_flush;
   logic                  fetch_valid;
   logic [DATA_WIDTH-1:0] fetch_data;
   logic                  fetch_err;
   logic                  load_we;
   logic                  load_re;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [DATA_WIDTH-1:0] load_wdata;
   logic [DATA_WIDTH-1:0] load_rdata;
   modport master (
      input  init_done, fetch_ready, fetch_valid, fetch_data, fetch_err, load_rdata,
      output fetch_req, fetch_addr, fetch_stall, fetch_flush, load_we, load_re, load_addr, load_wdata
   );
   modport slave (
      output init_done, fetch_ready, fetch_valid, fetch_data, fetch_err, load_rdata,
      input  fetch_req, fetch_addr, fetch_stall, fetch_flush, load_we, load_re, load_addr, load_wdata
   );
endinterface

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: synchronous-read instruction memory with stall/flush fetch port and a load port
// Ports:
//    clk    system clock, rising edge
//    reset  asynchronous active-high reset
//    bus    instr_mem_pipe_if.slave: fetch request/result, load port, init_done
module instr_mem_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 32,
   parameter bit INIT_CLEAR = 1'b1
) (
   input logic             clk,
   input logic             reset,
   instr_mem_pipe_if.slave bus
);
   localparam int OFS = $clog2(DATA_WIDTH / 8);
   localparam int IDX = $clog2(DEPTH);
   typedef enum logic {CLEAR, READY} state_t;
   state_t                state_q, state_d;
   logic [IDX-1:0]        clr_cnt_q, clr_cnt_d;
   logic [IDX-1:0]        f_idx, l_idx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q, rdata_d;
   logic                  valid_q, valid_d, err_q, err_d;
   logic                  ready, accept, unused_addr;
   // upper address bits are deliberately dropped: addresses wrap modulo DEPTH words
   assign f_idx = bus.fetch_addr[OFS+IDX-1:OFS];
   assign l_idx = bus.load_addr[OFS+IDX-1:OFS];
   assign unused_addr = ^{bus.fetch_addr, bus.load_addr};
   assign ready = state_q == READY;
   assign bus.init_done = ready;
   assign bus.fetch_ready = ready && !bus.fetch_stall;
   // flush wins over an otherwise-ready request
   assign accept = bus.fetch_req && bus.fetch_ready && !bus.fetch_flush;
   assign bus.fetch_valid = valid_q;
   assign bus.fetch_data = data_q;
   assign bus.fetch_err = err_q;
   assign bus.load_rdata = rdata_q;
   always_comb begin
      state_d = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == IDX'(DEPTH - 1)) state_d = READY;
      end
      valid_d = bus.fetch_flush ? 1'b0 : bus.fetch_stall ? valid_q : accept;
      data_d = accept ? mem[f_idx] : data_q;
      err_d = accept ? (bus.fetch_addr & ADDR_WIDTH'((1 << OFS) - 1)) != '0 : err_q;
      rdata_d = (ready && bus.load_re) ? mem[l_idx] : rdata_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= INIT_CLEAR ? CLEAR : READY;
         clr_cnt_q <= '0;
         valid_q <= 1'b0;
         data_q <= '0;
         err_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         clr_cnt_q <= clr_cnt_d;
         valid_q <= valid_d;
         data_q <= data_d;
         err_q <= err_d;
         rdata_q <= rdata_d;
      end
   // reads above sample the array before this write lands, giving read-before-write
   always_ff @(posedge clk)
      if (state_q == CLEAR) mem[clr_cnt_q] <= '0;
      else if (bus.load_we) mem[l_idx] <= bus.load_wdata;
endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb_instr_mem_pipe: scoreboard bench for instr_mem_pipe (DEPTH=16, INIT_CLEAR=1)
module tb_instr_mem_pipe;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          total = 0;
   int          bad = 0;
   logic        stall_at_edge = 1'b0;
   logic [32:0] exp_q [$];
   logic [31:0] model [16];

   instr_mem_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   instr_mem_pipe #(
      .DATA_WIDTH(32),
      .DEPTH(16),
      .ADDR_WIDTH(32),
      .INIT_CLEAR(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   always @(posedge clk) stall_at_edge <= bus.fetch_stall;

   always @(negedge clk)
      if (bus.fetch_valid === 1'b1 && !stall_at_edge) begin
         if (exp_q.size() == 0) chk("unexpected_valid", 64'(bus.fetch_valid), 64'd0);
         else chk("fetch", 64'({bus.fetch_err, bus.fetch_data}), 64'(exp_q.pop_front()));
      end

   task automatic cycle(input logic f, input logic [31:0] fa, input logic we, input logic re,
                        input logic [31:0] la, input logic [31:0] wd);
      logic [31:0] old_rd;
      bus.fetch_req = f;
      bus.fetch_addr = fa;
      bus.load_we = we;
      bus.load_re = re;
      bus.load_addr = la;
      bus.load_wdata = wd;
      if (f) exp_q.push_back({fa[1:0] != 2'b00, model[fa[5:2]]});
      old_rd = model[la[5:2]];
      if (we) model[la[5:2]] = wd;
      @(posedge clk); #1;
      if (re) chk("load_rdata", 64'(bus.load_rdata), 64'(old_rd));
      bus.fetch_req = 1'b0;
      bus.load_we = 1'b0;
      bus.load_re = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst_init_done", 64'(bus.init_done), 64'd0);
      chk("rst_ready", 64'(bus.fetch_ready), 64'd0);
      chk("rst_valid", 64'(bus.fetch_valid), 64'd0);
      chk("rst_data", 64'(bus.fetch_data), 64'd0);
      chk("rst_err", 64'(bus.fetch_err), 64'd0);
      chk("rst_rdata", 64'(bus.load_rdata), 64'd0);
   endtask

   task automatic release_and_clear();
      @(posedge clk); #1;
      bus.load_re = 1'b1;
      bus.load_addr = 32'h8;
      reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         chk("init_done", 64'(bus.init_done), 64'(i == 16));
         if (i == 1) begin
            chk("clear_load_ignored", 64'(bus.load_rdata), 64'd0);
            bus.load_re = 1'b0;
         end
      end
      chk("ready_after_clear", 64'(bus.fetch_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      bus.fetch_req = 1'b0;
      bus.fetch_addr = '0;
      bus.fetch_stall = 1'b0;
      bus.fetch_flush = 1'b0;
      bus.load_we = 1'b0;
      bus.load_re = 1'b0;
      bus.load_addr = '0;
      bus.load_wdata = '0;
      foreach (model[i]) model[i] = '0;
      #3 reset = 1'b1;
      #1 chk_reset();
      release_and_clear();
      for (int a = 0; a < 16; a++) cycle(1'b1, 32'(a * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'hDEADBEEF);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 32'h12345678);
      cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("b2b_valid0", 64'(bus.fetch_valid), 64'd1);
      cycle(1'b1, 32'hC, 1'b0, 1'b1, 32'h8, 32'h0);
      chk("b2b_valid1", 64'(bus.fetch_valid), 64'd1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'hC, 32'h0);
      chk("rdata_hold", 64'(bus.load_rdata), 64'hDEADBEEF);
      cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
      bus.fetch_stall = 1'b1;
      bus.fetch_req = 1'b1;
      bus.fetch_addr = 32'hC;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_data", 64'(bus.fetch_data), 64'hDEADBEEF);
         chk("stall_valid", 64'(bus.fetch_valid), 64'd1);
         chk("stall_ready", 64'(bus.fetch_ready), 64'd0);
      end
      bus.fetch_stall = 1'b0;
      bus.fetch_flush = 1'b1;
      @(posedge clk); #1;
      chk("flush_valid", 64'(bus.fetch_valid), 64'd0);
      bus.fetch_flush = 1'b0;
      bus.fetch_req = 1'b0;
      cycle(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle(1'b1, 32'h0A, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h11111111);
      cycle(1'b1, 32'h4, 1'b1, 1'b0, 32'h4, 32'hAAAA5555);
      cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h5A5A5A5A);
      cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("pre_reset_valid", 64'(bus.fetch_valid), 64'd1);
      bus.fetch_req = 1'b1;
      bus.fetch_addr = 32'h8;
      @(negedge clk); #1;
      reset = 1'b1;
      #1 chk_reset();
      bus.fetch_req = 1'b0;
      foreach (model[i]) model[i] = '0;
      release_and_clear();
      cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
